// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store path: access sizes, FSM states,
// and the helpers that map size/address onto byte lanes.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // Access attributes latched on entry to WAIT so load alignment does not
  // depend on the pipeline inputs staying frozen.
  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] lo;
  } mem_req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: store_rep = {4{d[7:0]}};
      SZ_HALF: store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if;
  logic        Mem_Req;
  logic        Mem_We;
  logic [31:0] Mem_Addr;
  logic [3:0]  Mem_BE;
  logic [31:0] Mem_WData;
  logic        Mem_Ack;
  logic [31:0] Mem_RData;

  modport master (
    output Mem_Req, Mem_We, Mem_Addr, Mem_BE, Mem_WData,
    input  Mem_Ack, Mem_RData
  );

  modport slave (
    input  Mem_Req, Mem_We, Mem_Addr, Mem_BE, Mem_WData,
    output Mem_Ack, Mem_RData
  );
endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a little-endian read word and extends it.
module mem_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{lo, 3'b000} +: 8];
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{~uns & b[7]}}, b};
      SZ_HALF: data = {{16{~uns & h[15]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one memory access per load/store, stalls the
// pipeline until ack or timeout, and returns aligned/extended load data.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               MemRead_MEM,
  input  logic               MemWrite_MEM,
  input  logic [1:0]         Mem_Size_MEM,
  input  logic               Load_Unsigned_MEM,
  input  logic [31:0]        ALU_Result_MEM,
  input  logic [31:0]        Write_Data_MEM,
  output logic [31:0]        Read_Data_MEM,
  output logic               Stall_MEM,
  output logic               Addr_Error,
  output logic               Bus_Error,
  mem_access_stage_if.master mem
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  mem_req_t    req_q;
  logic [31:0] load_data;
  logic        op_vld;
  logic        mis;

  assign op_vld = MemRead_MEM | MemWrite_MEM;
  assign mis    = is_misaligned(Mem_Size_MEM, ALU_Result_MEM[1:0]);

  // Misalignment only matters for the instruction being launched from IDLE.
  assign Addr_Error = (state == ST_IDLE) & op_vld & mis;
  assign Stall_MEM  = ((state == ST_IDLE) & op_vld & ~mis) | (state == ST_WAIT);

  mem_load_align u_align (
    .rdata (mem.Mem_RData),
    .lo    (req_q.lo),
    .size  (req_q.size),
    .uns   (req_q.uns),
    .data  (load_data)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      req_q         <= '0;
      Read_Data_MEM <= '0;
      Bus_Error     <= 1'b0;
      mem.Mem_Req   <= 1'b0;
      mem.Mem_We    <= 1'b0;
      mem.Mem_Addr  <= '0;
      mem.Mem_BE    <= '0;
      mem.Mem_WData <= '0;
    end else begin
      Bus_Error <= 1'b0;
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (op_vld) begin
            if (mis) begin
              Read_Data_MEM <= '0;
            end else begin
              // Write wins when both strobes are set.
              state         <= ST_WAIT;
              mem.Mem_Req   <= 1'b1;
              mem.Mem_We    <= MemWrite_MEM;
              mem.Mem_Addr  <= {ALU_Result_MEM[31:2], 2'b00};
              mem.Mem_BE    <= byte_en(Mem_Size_MEM, ALU_Result_MEM[1:0]);
              mem.Mem_WData <= store_rep(Mem_Size_MEM, Write_Data_MEM);
              req_q         <= '{size: Mem_Size_MEM, uns: Load_Unsigned_MEM,
                                 lo: ALU_Result_MEM[1:0]};
            end
          end
        end
        ST_WAIT: begin
          if (mem.Mem_Ack) begin
            state       <= ST_DONE;
            mem.Mem_Req <= 1'b0;
            if (!mem.Mem_We) Read_Data_MEM <= load_data;
          end else if (wait_cnt == TO_LAST) begin
            state         <= ST_DONE;
            mem.Mem_Req   <= 1'b0;
            Bus_Error     <= 1'b1;
            Read_Data_MEM <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
